fifoout_burst_arb: RTL and testbench

Round-robin burst arbiter that shares one downstream write port between N_CH prefetch-FIFO read interfaces in the read clock domain. Each channel presents first-word-fall-through data (rd_data/rd_vld, popped by rd_en). The block grants one channel at a time and drains exactly BURST_LEN words per grant. It tags every burst with its channel index and a last-beat marker, and feeds the frame-buffer write sequencer.

---
 rtl/fifoout_arb_pkg.sv | 29 ++
 rtl/fifoout_rr_pick.sv | 40 ++++
 rtl/fifoout_burst_arb.sv | 180 ++++++++++++++++++
 tb/tb_fifoout_burst_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifoout_arb_pkg.sv
// fifoout_arb_pkg: arbiter state type, width helper and width limits shared
// by the burst arbiter and its round-robin picker.
package fifoout_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // Number of bits needed to index 'value' items (at least one bit).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int N_CH_MAX      = 8;
    localparam int BURST_LEN_MAX = 256;
    localparam int CH_W_MAX      = clog2(N_CH_MAX);
    localparam int BEAT_W_MAX    = clog2(BURST_LEN_MAX);

endpackage

// File: rtl/fifoout_rr_pick.sv
// fifoout_rr_pick: combinational rotate-priority encoder. Returns the first
// asserted request at or after ptr, wrapping from N_CH-1 back to 0.
module fifoout_rr_pick
    import fifoout_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    logic [CH_W-1:0] cand;

    // Channel index 'off' positions after 'base', modulo N_CH.
    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_CH) begin
            sum = sum - N_CH;
        end
        return CH_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        gnt_idx = '0;
        cand    = '0;
        any     = |req;
        for (int off = N_CH - 1; off >= 0; off--) begin
            cand = wrap_idx(ptr, off);
            if (req[cand]) begin
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifoout_burst_arb.sv
// fifoout_burst_arb: round-robin burst arbiter draining BURST_LEN words per
// grant from N_CH first-word-fall-through FIFOs onto one write port.
// Optional feature macro: FIFOOUT_ARB_TIMEOUT_EN -- ends a burst stalled for
// TIMEOUT cycles with a single zero-data last beat (FLUSH state).
module fifoout_burst_arb
    import fifoout_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic [N_CH*DATA_W-1:0]   ch_rd_data,
    input  logic [N_CH-1:0]          ch_rd_vld,
    output logic [N_CH-1:0]          ch_rd_en,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_vld,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [clog2(N_CH)-1:0]   out_ch,
    output logic                     busy
);

    localparam int CH_W   = clog2(N_CH);
    localparam int BEAT_W = clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    // Reject unsupported parameter sets at elaboration time.
    if (N_CH < 2 || CH_W > CH_W_MAX) begin : g_bad_nch
        $error("fifoout_burst_arb: N_CH must be 2..8");
    end
    if (BURST_LEN < 2 || BEAT_W > BEAT_W_MAX) begin : g_bad_burst
        $error("fifoout_burst_arb: BURST_LEN must be 2..256");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifoout_burst_arb: TIMEOUT must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              busy_q;

    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic [CH_W-1:0]   next_ptr;
    logic              grant_vld;
    logic [DATA_W-1:0] grant_data;
    logic              beat;

`ifdef FIFOOUT_ARB_TIMEOUT_EN
    localparam int STALL_W = clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    fifoout_rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req     (ch_rd_vld),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign next_ptr   = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
    assign grant_vld  = ch_rd_vld[grant_q];
    assign grant_data = ch_rd_data[int'(grant_q)*DATA_W +: DATA_W];
    assign busy       = busy_q && !rd_rst;

    // Next-state and output decode; outputs are forced quiet while in reset.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat       = 1'b0;
        out_vld    = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        out_ch     = '0;
        ch_rd_en   = '0;
`ifdef FIFOOUT_ARB_TIMEOUT_EN
        stall_d    = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
`ifdef FIFOOUT_ARB_TIMEOUT_EN
                stall_d = '0;
`endif
            end
            BURST: begin
                out_vld           = grant_vld;
                out_data          = grant_data;
                out_ch            = grant_q;
                out_last          = grant_vld && (beat_cnt_q == LAST_BEAT);
                beat              = grant_vld && out_ready;
                ch_rd_en[grant_q] = beat;
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end
`ifdef FIFOOUT_ARB_TIMEOUT_EN
                if (beat) begin
                    stall_d = '0;
                end else if (!grant_vld) begin
                    if (stall_q == STALL_LIMIT) begin
                        stall_d = '0;
                        state_d = FLUSH;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
`ifdef FIFOOUT_ARB_TIMEOUT_EN
            FLUSH: begin
                out_vld  = 1'b1;
                out_last = 1'b1;
                out_ch   = grant_q;
                if (out_ready) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rd_rst) begin
            out_vld  = 1'b0;
            out_last = 1'b0;
            out_data = '0;
            out_ch   = '0;
            ch_rd_en = '0;
        end
    end

    // State, grant and round-robin registers with synchronous reset.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= (state_d != IDLE);
        end
    end

`ifdef FIFOOUT_ARB_TIMEOUT_EN
    // Stall counter for the burst timeout.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifoout_burst_arb.sv
// tb_fifoout_burst_arb: directed bench for the round-robin burst arbiter.
// Each channel is modelled as a FIFO holding 'total' words, popped by
// ch_rd_en; word n of channel k reads 0xC000_0000 | k<<16 | n.
module tb_fifoout_burst_arb;

    localparam int N_CH      = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 16;

    logic                   clk = 1'b0;
    logic                   rd_rst;
    logic [N_CH*DATA_W-1:0] ch_rd_data;
    logic [N_CH-1:0]        ch_rd_vld;
    logic [N_CH-1:0]        ch_rd_en;
    logic [DATA_W-1:0]      out_data;
    logic                   out_vld;
    logic                   out_ready;
    logic                   out_last;
    logic [1:0]             out_ch;
    logic                   busy;

    int              total [N_CH];
    int              popped [N_CH];
    logic [N_CH-1:0] stall;
    int              errors = 0;
    int              checks = 0;

    fifoout_burst_arb #(
        .N_CH      (N_CH),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (8)
    ) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .ch_rd_data (ch_rd_data),
        .ch_rd_vld  (ch_rd_vld),
        .ch_rd_en   (ch_rd_en),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_ch     (out_ch),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word(input int k, input int n);
        return 32'hC000_0000 | (32'(k) << 16) | 32'(n);
    endfunction

    // FIFO heads: valid while words remain and the channel is not held off.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_rd_vld[k] = ((total[k] - popped[k]) > 0) && !stall[k];
            ch_rd_data[k*DATA_W +: DATA_W] = word(k, popped[k]);
        end
    end

    // FIFO pops; the FIFOs share the arbiter reset.
    always @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (rd_rst) popped[k] <= 0;
            else if (ch_rd_en[k]) popped[k] <= popped[k] + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rd_rst = 1'b1;
        out_ready = 1'b0;
        stall = '0;
        for (int k = 0; k < N_CH; k++) total[k] = 0;
        repeat (2) @(negedge clk);
        rd_rst = 1'b0;
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        out_ready = 1'b1;
        stall = '0;
        for (int k = 0; k < N_CH; k++) total[k] = 0;
        total[1] = 16;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({out_vld, out_last, busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {out_vld, out_last, busy}); end
        checks++; if (ch_rd_en !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rd_en: got %b want 0000", ch_rd_en); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_ch: got %0d want 0", out_ch); end
        @(negedge clk);
        rd_rst = 1'b0;
        total[1] = 0;
        #1;
        checks++; if ({out_vld, out_last, busy, ch_rd_en} !== 7'b0) begin errors++; $display("[TB] FAIL reset_release: got %b want 0", {out_vld, out_last, busy, ch_rd_en}); end
    endtask

    task automatic test_single();
        do_reset();
        total[1] = 16;
        out_ready = 1'b1;
        #1;
        checks++; if ({out_vld, busy} !== 2'b00) begin errors++; $display("[TB] FAIL single_latency: got %b want 00", {out_vld, busy}); end
        for (int i = 0; i < BURST_LEN; i++) begin
            @(negedge clk); #1;
            checks++; if ({out_vld, busy} !== 2'b11) begin errors++; $display("[TB] FAIL single_vld beat %0d: got %b want 11", i, {out_vld, busy}); end
            checks++; if (out_ch !== 2'd1) begin errors++; $display("[TB] FAIL single_ch beat %0d: got %0d want 1", i, out_ch); end
            checks++; if (out_data !== word(1, i)) begin errors++; $display("[TB] FAIL single_data beat %0d: got %h want %h", i, out_data, word(1, i)); end
            checks++; if (out_last !== (i == BURST_LEN - 1)) begin errors++; $display("[TB] FAIL single_last beat %0d: got %b", i, out_last); end
            checks++; if (ch_rd_en !== 4'b0010) begin errors++; $display("[TB] FAIL single_rd_en beat %0d: got %b want 0010", i, ch_rd_en); end
        end
        @(negedge clk); #1;
        checks++; if ({out_vld, busy} !== 2'b00) begin errors++; $display("[TB] FAIL single_end: got %b want 00", {out_vld, busy}); end
        checks++; if (popped[1] !== 16) begin errors++; $display("[TB] FAIL single_pops: got %0d want 16", popped[1]); end
    endtask

    task automatic test_round_robin();
        int ch;
        do_reset();
        for (int k = 0; k < N_CH; k++) total[k] = 1000;
        out_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            ch = b % N_CH;
            for (int i = 0; i < BURST_LEN; i++) begin
                @(negedge clk); #1;
                checks++; if ({out_vld, busy} !== 2'b11) begin errors++; $display("[TB] FAIL rr_vld burst %0d beat %0d: got %b want 11", b, i, {out_vld, busy}); end
                checks++; if (out_ch !== 2'(ch)) begin errors++; $display("[TB] FAIL rr_ch burst %0d beat %0d: got %0d want %0d", b, i, out_ch, ch); end
                checks++; if (out_data !== word(ch, (b / N_CH) * BURST_LEN + i)) begin errors++; $display("[TB] FAIL rr_data burst %0d beat %0d: got %h", b, i, out_data); end
                checks++; if (out_last !== (i == BURST_LEN - 1)) begin errors++; $display("[TB] FAIL rr_last burst %0d beat %0d: got %b", b, i, out_last); end
                checks++; if (ch_rd_en !== 4'(1 << ch)) begin errors++; $display("[TB] FAIL rr_rd_en burst %0d beat %0d: got %b", b, i, ch_rd_en); end
            end
            if (b < 4) begin
                @(negedge clk); #1;
                checks++; if ({out_vld, busy, ch_rd_en} !== 6'b0) begin errors++; $display("[TB] FAIL rr_bubble after burst %0d: got %b want 0", b, {out_vld, busy, ch_rd_en}); end
            end
        end
    endtask

    task automatic test_ready_toggle();
        int beats;
        do_reset();
        total[3] = 16;
        out_ready = 1'b0;
        beats = 0;
        for (int j = 0; j < 2 * BURST_LEN; j++) begin
            @(negedge clk);
            out_ready = (j % 2 == 0);
            #1;
            if (out_ready && beats < BURST_LEN) begin
                checks++; if (ch_rd_en !== 4'b1000) begin errors++; $display("[TB] FAIL toggle_rd_en cycle %0d: got %b want 1000", j, ch_rd_en); end
                checks++; if (out_data !== word(3, beats)) begin errors++; $display("[TB] FAIL toggle_data cycle %0d: got %h want %h", j, out_data, word(3, beats)); end
                checks++; if (out_last !== (beats == BURST_LEN - 1)) begin errors++; $display("[TB] FAIL toggle_last cycle %0d: got %b", j, out_last); end
                beats++;
            end else begin
                checks++; if (ch_rd_en !== 4'b0000) begin errors++; $display("[TB] FAIL toggle_idle_rd_en cycle %0d: got %b want 0000", j, ch_rd_en); end
                if (beats < BURST_LEN) begin
                    checks++; if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL toggle_vld cycle %0d: got %b want 1", j, out_vld); end
                end
            end
        end
        checks++; if (popped[3] !== 16) begin errors++; $display("[TB] FAIL toggle_pops: got %0d want 16", popped[3]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL toggle_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int beats;
        int stallLeft;
        do_reset();
        total[2] = 16;
        out_ready = 1'b1;
        beats = 0;
        stallLeft = 10;
        for (int cyc = 0; cyc < BURST_LEN + 10; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                total[0] = 1000; total[1] = 1000; total[3] = 1000;
            end
            stall[2] = (beats == 5 && stallLeft > 0);
            if (stall[2]) stallLeft--;
            #1;
            checks++; if ({busy, out_ch} !== 3'b110) begin errors++; $display("[TB] FAIL stall_grant cycle %0d: got busy=%b ch=%0d want busy=1 ch=2", cyc, busy, out_ch); end
            if (stall[2]) begin
                checks++; if ({out_vld, ch_rd_en} !== 5'b0) begin errors++; $display("[TB] FAIL stall_hold cycle %0d: got %b want 0", cyc, {out_vld, ch_rd_en}); end
            end else begin
                checks++; if (ch_rd_en !== 4'b0100) begin errors++; $display("[TB] FAIL stall_rd_en cycle %0d: got %b want 0100", cyc, ch_rd_en); end
                checks++; if (out_data !== word(2, beats)) begin errors++; $display("[TB] FAIL stall_data cycle %0d: got %h want %h", cyc, out_data, word(2, beats)); end
                checks++; if (out_last !== (beats == BURST_LEN - 1)) begin errors++; $display("[TB] FAIL stall_last cycle %0d: got %b", cyc, out_last); end
                beats++;
            end
        end
        stall[2] = 1'b0;
        @(negedge clk); #1;
        checks++; if ({out_vld, busy} !== 2'b00) begin errors++; $display("[TB] FAIL stall_end: got %b want 00", {out_vld, busy}); end
        checks++; if (popped[2] !== 16) begin errors++; $display("[TB] FAIL stall_pops: got %0d want 16", popped[2]); end
        checks++; if (popped[0] + popped[1] + popped[3] !== 0) begin errors++; $display("[TB] FAIL stall_other_pops: got %0d want 0", popped[0] + popped[1] + popped[3]); end
    endtask

`ifdef FIFOOUT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        total[0] = 16;
        total[1] = 16;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (out_data !== word(0, i) || ch_rd_en !== 4'b0001) begin errors++; $display("[TB] FAIL timeout_beat %0d: got %h/%b", i, out_data, ch_rd_en); end
        end
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            stall[0] = 1'b1;
            #1;
            checks++; if ({out_vld, busy, ch_rd_en} !== 6'b010000) begin errors++; $display("[TB] FAIL timeout_stall %0d: got %b want 010000", s, {out_vld, busy, ch_rd_en}); end
        end
        @(negedge clk); #1;
        checks++; if ({out_vld, out_last, ch_rd_en} !== 6'b110000 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL timeout_flush: got %b data %h want 110000 data 0", {out_vld, out_last, ch_rd_en}, out_data); end
        @(negedge clk); #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL timeout_bubble: got %b want 0", out_vld); end
        @(negedge clk); #1;
        checks++; if (out_ch !== 2'd1 || out_data !== word(1, 0) || ch_rd_en !== 4'b0010) begin errors++; $display("[TB] FAIL timeout_next: got ch %0d data %h en %b", out_ch, out_data, ch_rd_en); end
        checks++; if (popped[0] !== 3) begin errors++; $display("[TB] FAIL timeout_pops: got %0d want 3", popped[0]); end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        total[0] = 1000;
        total[1] = 1000;
        out_ready = 1'b1;
        repeat (BURST_LEN + 1 + 6) @(negedge clk);
        @(negedge clk); #1;
        checks++; if ({out_vld, out_ch} !== 3'b101) begin errors++; $display("[TB] FAIL midrst_pre: got %b want 101", {out_vld, out_ch}); end
        rd_rst = 1'b1;
        #1;
        checks++; if ({out_vld, out_last, busy, ch_rd_en} !== 7'b0) begin errors++; $display("[TB] FAIL midrst_during: got %b want 0", {out_vld, out_last, busy, ch_rd_en}); end
        @(negedge clk);
        rd_rst = 1'b0;
        #1;
        checks++; if ({out_vld, out_last, busy, ch_rd_en} !== 7'b0) begin errors++; $display("[TB] FAIL midrst_after: got %b want 0", {out_vld, out_last, busy, ch_rd_en}); end
        @(negedge clk); #1;
        checks++; if (out_ch !== 2'd0 || out_vld !== 1'b1 || out_data !== word(0, 0)) begin errors++; $display("[TB] FAIL midrst_rr_restart: got ch %0d vld %b data %h want ch 0", out_ch, out_vld, out_data); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        rd_rst = 1'b1;
        out_ready = 1'b0;
        stall = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_ready_toggle();
        test_stall();
`ifdef FIFOOUT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
